// File: rtl/wb_port_arbiter.sv
// Writeback stage: decodes the MEM/WB latch and shares the register-file write
// port with a host write channel. A bounded-starvation arbiter sits in front of the port.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned STATUS_REG   = 30,
   parameter int unsigned LINK_REG     = 31
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ir_in,
   input  logic [31:0] o_in,
   input  logic [31:0] d_in,
   input  logic        isRStatus_in,
   input  logic [31:0] rStatus_in,
   input  logic        valid_in,
   output logic        stall_out,
   input  logic        host_req,
   input  logic [4:0]  host_reg,
   input  logic [31:0] host_data,
   output logic        host_ack,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_SETX  = 5'b10101;

   logic [CW-1:0] starve_cnt;
   logic          ack_pending;

   logic [4:0]  op;
   logic [4:0]  rd;
   logic        dec_write;
   logic [4:0]  dec_reg;
   logic [31:0] dec_data;
   logic        pipe_wants;
   logic        host_live;
   logic        starve_max;
   logic        host_wins;

   // Destination/data select; an exception flag overrides the normal destination.
   always_comb begin
      op        = ir_in[31:27];
      rd        = ir_in[26:22];
      dec_write = 1'b0;
      dec_reg   = rd;
      dec_data  = o_in;
      if (isRStatus_in) begin
         dec_write = 1'b1;
         dec_reg   = 5'(STATUS_REG);
         dec_data  = rStatus_in;
      end else begin
         case (op)
            OP_RTYPE, OP_ADDI: dec_write = 1'b1;
            OP_LW: begin
               dec_write = 1'b1;
               dec_data  = d_in;
            end
            OP_JAL: begin
               dec_write = 1'b1;
               dec_reg   = 5'(LINK_REG);
            end
            OP_SETX: begin
               dec_write = 1'b1;
               dec_reg   = 5'(STATUS_REG);
               dec_data  = {5'b0, ir_in[26:0]};
            end
            default: dec_write = 1'b0;
         endcase
      end
   end

   // Writes to r0 are dropped here so they never contend for the port.
   assign pipe_wants = valid_in & dec_write & (dec_reg != 5'd0);
   assign host_live  = host_req & ~ack_pending;
   assign starve_max = (starve_cnt == CW'(STARVE_LIMIT));
   assign host_wins  = host_live & (~pipe_wants | starve_max);
   assign stall_out  = reset & pipe_wants & host_wins;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= 5'd0;
         data_writeReg    <= 32'd0;
         host_ack         <= 1'b0;
         ack_pending      <= 1'b0;
         starve_cnt       <= '0;
      end else begin
         host_ack    <= host_wins;
         ack_pending <= host_wins;
         if (host_wins) begin
            ctrl_writeEnable <= (host_reg != 5'd0);
            ctrl_writeReg    <= host_reg;
            data_writeReg    <= host_data;
         end else if (pipe_wants) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= dec_reg;
            data_writeReg    <= dec_data;
         end else begin
            ctrl_writeEnable <= 1'b0;
         end
         // A live host that keeps losing counts up; a grant or an idle host resets it.
         if (host_wins || !host_live) begin
            starve_cnt <= '0;
         end else if (pipe_wants && !starve_max) begin
            starve_cnt <= starve_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against a cycle-level
// reference model of the writeback/host arbitration rules.
module tb_wb_port_arbiter;

   localparam int LIMIT = 4;

   logic        clock;
   logic        reset;
   logic [31:0] ir_in;
   logic [31:0] o_in;
   logic [31:0] d_in;
   logic        isRStatus_in;
   logic [31:0] rStatus_in;
   logic        valid_in;
   logic        stall_out;
   logic        host_req;
   logic [4:0]  host_reg;
   logic [31:0] host_data;
   logic        host_ack;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   bit          m_we;
   logic [4:0]  m_reg;
   logic [31:0] m_data;
   bit          m_ack;
   bit          m_pend;
   int          m_starve;

   wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .STATUS_REG(30), .LINK_REG(31)) dut (
      .clock(clock), .reset(reset), .ir_in(ir_in), .o_in(o_in), .d_in(d_in),
      .isRStatus_in(isRStatus_in), .rStatus_in(rStatus_in), .valid_in(valid_in),
      .stall_out(stall_out), .host_req(host_req), .host_reg(host_reg),
      .host_data(host_data), .host_ack(host_ack), .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd);
      return {op, rd, 22'd0};
   endfunction

   function automatic void model_decode(output bit w, output logic [4:0] r, output logic [31:0] v);
      int op;
      op = int'(ir_in[31:27]);
      w  = 1'b1;
      r  = ir_in[26:22];
      v  = o_in;
      if (isRStatus_in) begin
         r = 5'd30;
         v = rStatus_in;
      end else if (op == 0 || op == 5) begin
         w = 1'b1;
      end else if (op == 8) begin
         v = d_in;
      end else if (op == 3) begin
         r = 5'd31;
      end else if (op == 21) begin
         r = 5'd30;
         v = ir_in & 32'h07FF_FFFF;
      end else begin
         w = 1'b0;
      end
   endfunction

   function automatic void model_reset();
      m_we = 0; m_reg = 0; m_data = 0; m_ack = 0; m_pend = 0; m_starve = 0;
   endfunction

   // One clock: check combinational stall, advance model and DUT, check outputs.
   task automatic step(input string tag);
      bit          w;
      logic [4:0]  r;
      logic [31:0] v;
      bit          want, live, wins;
      #1;
      model_decode(w, r, v);
      want = w && (valid_in === 1'b1) && (r != 5'd0);
      live = (host_req === 1'b1) && !m_pend;
      wins = live && (!want || m_starve == LIMIT);
      chk({tag, ".stall"}, 32'(stall_out), 32'(want && wins));
      @(posedge clock);
      if (wins) begin
         m_we = (host_reg != 5'd0); m_reg = host_reg; m_data = host_data;
      end else if (want) begin
         m_we = 1; m_reg = r; m_data = v;
      end else begin
         m_we = 0;
      end
      m_ack  = wins;
      m_pend = wins;
      if (wins || !live) m_starve = 0;
      else if (m_starve < LIMIT) m_starve = m_starve + 1;
      #1;
      chk({tag, ".we"},   32'(ctrl_writeEnable), 32'(m_we));
      chk({tag, ".reg"},  32'(ctrl_writeReg),    32'(m_reg));
      chk({tag, ".data"}, data_writeReg,         m_data);
      chk({tag, ".ack"},  32'(host_ack),         32'(m_ack));
   endtask

   task automatic set_pipe(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d);
      ir_in = ir; o_in = o; d_in = d; valid_in = 1'b1; isRStatus_in = 1'b0;
   endtask

   initial begin
      clock = 0; reset = 0;
      rStatus_in = 0; isRStatus_in = 0; host_req = 1; host_reg = 5'd3; host_data = 32'h55;
      set_pipe(enc(5'b00000, 5'd5), 32'h11, 32'h0);
      model_reset();

      // Reset held with live traffic and a host request.
      #2;
      chk("rst.stall", 32'(stall_out), 32'd0);
      @(posedge clock); #1;
      chk("rst.we",   32'(ctrl_writeEnable), 32'd0);
      chk("rst.reg",  32'(ctrl_writeReg),    32'd0);
      chk("rst.data", data_writeReg,         32'd0);
      chk("rst.ack",  32'(host_ack),         32'd0);
      reset = 1; host_req = 0;

      // Decode sweep.
      step("add5");
      chk("add5.exp", {ctrl_writeEnable, 26'd0, ctrl_writeReg}, {1'b1, 26'd0, 5'd5});
      chk("add5.val", data_writeReg, 32'h11);
      set_pipe(enc(5'b01000, 5'd7), 32'h99, 32'hABCD);         step("lw7");
      chk("lw7.val", data_writeReg, 32'hABCD);
      set_pipe(enc(5'b00011, 5'd2), 32'h40, 32'h0);            step("jal");
      chk("jal.reg", 32'(ctrl_writeReg), 32'd31);
      set_pipe({5'b10101, 27'h123}, 32'h7, 32'h0);             step("setx");
      chk("setx.val", data_writeReg, 32'h123);
      set_pipe(enc(5'b00111, 5'd6), 32'h7, 32'h0);             step("sw");
      chk("sw.we", 32'(ctrl_writeEnable), 32'd0);
      set_pipe(enc(5'b00000, 5'd0), 32'h7, 32'h0);             step("add0");
      chk("add0.we", 32'(ctrl_writeEnable), 32'd0);
      set_pipe(enc(5'b00000, 5'd3), 32'h7, 32'h0);
      isRStatus_in = 1; rStatus_in = 32'h1;                    step("exc");
      chk("exc.reg", 32'(ctrl_writeReg), 32'd30);
      chk("exc.val", data_writeReg, 32'h1);
      valid_in = 0;                                            step("bubble_exc");
      chk("bubble_exc.we", 32'(ctrl_writeEnable), 32'd0);
      isRStatus_in = 0;

      // Idle host write, request held through the ack cycle.
      host_req = 1; host_reg = 5'd9; host_data = 32'hDEAD;     step("host");
      chk("host.ack", 32'(host_ack), 32'd1);
      chk("host.val", data_writeReg, 32'hDEAD);
      step("host_hold");
      chk("host_hold.we", 32'(ctrl_writeEnable), 32'd0);
      host_req = 0;                                            step("idle");

      // Host to r0: acked, no enable.
      host_req = 1; host_reg = 5'd0; host_data = 32'h1;        step("host_r0");
      chk("host_r0.ack", 32'(host_ack), 32'd1);
      host_req = 0;                                            step("idle2");

      // Starvation: four pipeline wins, then a forced host grant with stall.
      host_req = 1; host_reg = 5'd12; host_data = 32'hCAFE;
      for (int i = 1; i <= LIMIT; i++) begin
         set_pipe(enc(5'b00000, 5'd4), 32'(i), 32'h0);
         step("starve");
         chk("starve.pipe", data_writeReg, 32'(i));
      end
      set_pipe(enc(5'b00000, 5'd4), 32'h5, 32'h0);
      #1;
      chk("starve.stall_now", 32'(stall_out), 32'd1);
      step("forced");
      chk("forced.val", data_writeReg, 32'hCAFE);
      host_req = 0;                                            step("replay");
      chk("replay.val", data_writeReg, 32'h5);

      // Async reset across the edge that would register a host grant.
      valid_in = 0; host_req = 1; host_reg = 5'd9; host_data = 32'hBEEF;
      #3;
      reset = 0;
      #1;
      chk("arst.data_now", data_writeReg, 32'd0);
      chk("arst.stall", 32'(stall_out), 32'd0);
      @(posedge clock); #1;
      chk("arst.ack", 32'(host_ack), 32'd0);
      chk("arst.we",  32'(ctrl_writeEnable), 32'd0);
      reset = 1; host_req = 0;
      model_reset();
      step("post_arst");

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] ops [8];
         ops = '{5'b00000, 5'b00101, 5'b01000, 5'b00011, 5'b10101, 5'b00111, 5'b11111, 5'b00000};
         ir_in        = {ops[$urandom_range(7)], 5'($urandom_range(3)), 22'($urandom)};
         o_in         = $urandom;
         d_in         = $urandom;
         valid_in     = ($urandom_range(9) < 8);
         isRStatus_in = ($urandom_range(9) == 0);
         rStatus_in   = $urandom;
         host_req     = ($urandom_range(9) < 4);
         host_reg     = 5'($urandom_range(31));
         host_data    = $urandom;
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
